// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if -- E-stage bundle between the pipeline and the MDU sequencer.
//
// Signals:
//   E_start   E-stage instruction is mult/multu/div/divu/msub
//   E_MDUop   4-bit MDU op code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 msub)
//   E_A, E_B  forwarded rs / rt values
//   D_md_use  D-stage instruction is an md, mf or mt op
//   busy      an operation is in flight
//   stall     freeze F/D and bubble E
//   HI, LO    committed HI/LO registers
//   MDUout    HI for mfhi, LO for mflo, else 0
//
// Modports: master drives the pipeline side (decoder / bench), slave is the sequencer.
interface mdu_sequencer_if;
   logic        E_start;
   logic [3:0]  E_MDUop;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        D_md_use;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUout;

   modport master (
      output E_start, E_MDUop, E_A, E_B, D_md_use,
      input  busy, stall, HI, LO, MDUout
   );

   modport slave (
      input  E_start, E_MDUop, E_A, E_B, D_md_use,
      output busy, stall, HI, LO, MDUout
   );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer -- multi-cycle controller for the multiply/divide unit (E stage).
//
// Accepts MDU ops, computes the result at issue into a pending buffer, counts
// down MULT_LAT / DIV_LAT cycles, then commits the pending result to HI/LO.
// While busy it stalls any MDU-using instruction in D. mthi/mtlo write HI/LO
// directly when idle; mfhi/mflo read the committed HI/LO through MDUout.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset, clears all state
//   bus    mdu_sequencer_if.slave (E_start, E_MDUop, E_A, E_B, D_md_use in;
//          busy, stall, HI, LO, MDUout out)
//
// Parameters: MULT_LAT (1..15) busy cycles for mult/multu/msub,
//             DIV_LAT  (1..15) busy cycles for div/divu.
//
// Optional feature: define MDU_MSUB_EN to enable op 9 (msub),
// {HI,LO} <= {HI,LO} - signed(A)*signed(B). Without it op 9 acts as op 0.
module mdu_sequencer #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic            clk,
   input  logic            reset,
   mdu_sequencer_if.slave  bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;

   // What the commit does with the pending pair.
   localparam logic [1:0] PM_WRITE = 2'd0;   // overwrite HI/LO
   localparam logic [1:0] PM_SUB   = 2'd1;   // subtract from HI/LO at commit time
   localparam logic [1:0] PM_KEEP  = 2'd2;   // divide by zero: leave HI/LO alone

   localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
   localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [1:0]  pend_mode_q, pend_mode_d;

   logic [63:0] prod_s_s, prod_u_s;
   logic [31:0] div_b_s, abs_a_s, abs_b_s, mag_q_s, mag_r_s;
   logic [31:0] sq_s, sr_s, uq_s, ur_s;
   logic        is_start_op_s;
   logic [3:0]  start_lat_s;
   logic [31:0] start_hi_s, start_lo_s;
   logic [1:0]  start_mode_s;
   logic [63:0] sub_res_s;

   // Datapath: products and quotients for the op currently in E.
   always_comb begin
      prod_s_s = {{32{bus.E_A[31]}}, bus.E_A} * {{32{bus.E_B[31]}}, bus.E_B};
      prod_u_s = {32'd0, bus.E_A} * {32'd0, bus.E_B};
      // A zero divisor is replaced by 1 so the divider never sees 0; the
      // result is discarded anyway (PM_KEEP).
      div_b_s  = (bus.E_B == 32'd0) ? 32'd1 : bus.E_B;
      abs_a_s  = bus.E_A[31] ? (32'd0 - bus.E_A) : bus.E_A;
      abs_b_s  = div_b_s[31] ? (32'd0 - div_b_s) : div_b_s;
      mag_q_s  = abs_a_s / abs_b_s;
      mag_r_s  = abs_a_s % abs_b_s;
      // Truncating signed divide via magnitudes; 0x80000000 / -1 wraps to
      // 0x80000000 with remainder 0 naturally.
      sq_s     = (bus.E_A[31] ^ div_b_s[31]) ? (32'd0 - mag_q_s) : mag_q_s;
      sr_s     = bus.E_A[31] ? (32'd0 - mag_r_s) : mag_r_s;
      uq_s     = bus.E_A / div_b_s;
      ur_s     = bus.E_A % div_b_s;
   end

   // Start decode: which ops launch a multi-cycle operation and what they produce.
   always_comb begin
      is_start_op_s = 1'b0;
      start_lat_s   = 4'd0;
      start_hi_s    = 32'd0;
      start_lo_s    = 32'd0;
      start_mode_s  = PM_WRITE;
      case (bus.E_MDUop)
         OP_MULT: begin
            is_start_op_s = 1'b1;
            start_lat_s   = MULT_LAT_C;
            {start_hi_s, start_lo_s} = prod_s_s;
         end
         OP_MULTU: begin
            is_start_op_s = 1'b1;
            start_lat_s   = MULT_LAT_C;
            {start_hi_s, start_lo_s} = prod_u_s;
         end
         OP_DIV: begin
            is_start_op_s = 1'b1;
            start_lat_s   = DIV_LAT_C;
            start_hi_s    = sr_s;
            start_lo_s    = sq_s;
            start_mode_s  = (bus.E_B == 32'd0) ? PM_KEEP : PM_WRITE;
         end
         OP_DIVU: begin
            is_start_op_s = 1'b1;
            start_lat_s   = DIV_LAT_C;
            start_hi_s    = ur_s;
            start_lo_s    = uq_s;
            start_mode_s  = (bus.E_B == 32'd0) ? PM_KEEP : PM_WRITE;
         end
`ifdef MDU_MSUB_EN
         OP_MSUB: begin
            is_start_op_s = 1'b1;
            start_lat_s   = MULT_LAT_C;
            {start_hi_s, start_lo_s} = prod_s_s;
            start_mode_s  = PM_SUB;
         end
`else
         OP_MSUB: begin
            is_start_op_s = 1'b0;
         end
`endif
         default: begin
            is_start_op_s = 1'b0;
         end
      endcase
   end

   // Sequencer next state: issue, countdown, commit, and idle-time mthi/mtlo.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      pend_hi_d   = pend_hi_q;
      pend_lo_d   = pend_lo_q;
      pend_mode_d = pend_mode_q;
      sub_res_s   = {hi_q, lo_q} - {pend_hi_q, pend_lo_q};
      case (state_q)
         ST_IDLE: begin
            if (bus.E_start && is_start_op_s) begin
               state_d     = ST_BUSY;
               cnt_d       = start_lat_s;
               busy_d      = 1'b1;
               pend_hi_d   = start_hi_s;
               pend_lo_d   = start_lo_s;
               pend_mode_d = start_mode_s;
            end else begin
               case (bus.E_MDUop)
                  OP_MTHI: hi_d = bus.E_A;
                  OP_MTLO: lo_d = bus.E_A;
                  default: hi_d = hi_q;
               endcase
            end
         end
         ST_BUSY: begin
            // New starts and mthi/mtlo are ignored here; the stall keeps them out.
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               busy_d  = 1'b0;
               case (pend_mode_q)
                  PM_WRITE: begin
                     hi_d = pend_hi_q;
                     lo_d = pend_lo_q;
                  end
                  PM_SUB: begin
                     {hi_d, lo_d} = sub_res_s;
                  end
                  default: begin
                     hi_d = hi_q;
                     lo_d = lo_q;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         busy_q      <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         pend_hi_q   <= 32'd0;
         pend_lo_q   <= 32'd0;
         pend_mode_q <= PM_WRITE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         pend_hi_q   <= pend_hi_d;
         pend_lo_q   <= pend_lo_d;
         pend_mode_q <= pend_mode_d;
      end
   end

   // Outputs: stall and MDUout are combinational on the current E/D inputs.
   always_comb begin
      bus.busy  = busy_q;
      bus.HI    = hi_q;
      bus.LO    = lo_q;
      // Only ops that really launch count as a start, so a disabled msub never stalls.
      bus.stall = bus.D_md_use & ((bus.E_start & is_start_op_s) | busy_q);
      case (bus.E_MDUop)
         OP_MFHI: bus.MDUout = hi_q;
         OP_MFLO: bus.MDUout = lo_q;
         default: bus.MDUout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } sb_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   sb_t  sbq[$];

   mdu_sequencer_if bus_if ();

   mdu_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // A new start or an mt while busy must never reach the DUT.
   always @(negedge clk) begin
      if (!reset && bus_if.busy &&
          (bus_if.E_start || bus_if.E_MDUop == 4'd7 || bus_if.E_MDUop == 4'd8)) begin
         errors++;
         $display("FAIL start_or_mt_while_busy: op=%0d", bus_if.E_MDUop);
      end
   end

   function automatic sb_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
      sb_t r;
      int ia, ib;
      longint sa, sb;
      longint unsigned p;
      ia = a; ib = b; sa = ia; sb = ib;
      r.hi = hi; r.lo = lo;
      case (op)
         4'd1: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
         4'd3: if (b != 32'd0) begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
         4'd4: if (b != 32'd0) begin r.lo = a / b; r.hi = a % b; end
         default: r.hi = hi;
      endcase
      return r;
   endfunction

   // Issue one multi-cycle op now (caller sits mid-cycle), then follow it to commit.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
      int   lat, cnt;
      logic done, bad;
      sb_t  e;
      lat = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
      bus_if.E_start = 1'b1; bus_if.E_MDUop = op; bus_if.E_A = a; bus_if.E_B = b;
      bus_if.D_md_use = 1'b1;
      #1;
      chk({name, " stall_at_issue"}, 32'(bus_if.stall), 32'd1);
      @(posedge clk); #1;
      bus_if.E_start = 1'b0; bus_if.E_MDUop = 4'd0; bus_if.E_A = 32'd0; bus_if.E_B = 32'd0;
      cnt = 0; done = 1'b0; bad = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus_if.busy) begin
            cnt++;
            if (!bus_if.stall || bus_if.HI !== m_hi || bus_if.LO !== m_lo) bad = 1'b1;
         end else begin
            done = 1'b1;
         end
      end
      chk({name, " completed"}, 32'(done), 32'd1);
      chk({name, " busy_cycles"}, 32'(cnt), 32'(lat));
      chk({name, " stall_hold_while_busy"}, 32'(bad), 32'd0);
      chk({name, " stall_after"}, 32'(bus_if.stall), 32'd0);
      if (sbq.size() == 0) begin
         chk({name, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk({name, " HI"}, bus_if.HI, e.hi);
         chk({name, " LO"}, bus_if.LO, e.lo);
         m_hi = e.hi; m_lo = e.lo;
      end
   endtask

   task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
      sb_t e;
      e.hi = hi; e.lo = lo;
      sbq.push_back(e);
   endtask

   task automatic mt_pair(input logic [31:0] hv, input logic [31:0] lv);
      bus_if.D_md_use = 1'b0; bus_if.E_start = 1'b0;
      @(posedge clk); #1;
      bus_if.E_MDUop = 4'd7; bus_if.E_A = hv;
      @(posedge clk); #1;
      bus_if.E_MDUop = 4'd8; bus_if.E_A = lv;
      @(posedge clk); #1;
      bus_if.E_MDUop = 4'd0; bus_if.E_A = 32'd0;
      @(negedge clk);
      m_hi = hv; m_lo = lv;
   endtask

   vec_t vecs[10];

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      logic        seen;
      checks = 0; errors = 0; m_hi = 32'd0; m_lo = 32'd0;

      vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
      vecs[1] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
      vecs[2] = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, "divu_by_zero"};
      vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
      vecs[4] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mult_maxpos"};
      vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
      vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minneg"};
      vecs[7] = '{4'd3, 32'd5,        32'd0,        32'h40000000, 32'h00000000, "div_by_zero"};
      vecs[8] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "b2b_multu"};
      vecs[9] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, "b2b_divu"};

      // Reset state; stall follows its equation even during reset.
      reset = 1'b1;
      bus_if.E_start = 1'b1; bus_if.E_MDUop = 4'd1; bus_if.E_A = 32'd3; bus_if.E_B = 32'd4;
      bus_if.D_md_use = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(bus_if.busy), 32'd0);
      chk("reset HI", bus_if.HI, 32'd0);
      chk("reset LO", bus_if.LO, 32'd0);
      chk("reset stall_equation", 32'(bus_if.stall), 32'd1);
      reset = 1'b0; bus_if.E_start = 1'b0; bus_if.E_MDUop = 4'd0;
      bus_if.E_A = 32'd0; bus_if.E_B = 32'd0; bus_if.D_md_use = 1'b0;
      @(negedge clk);

      // Table of arithmetic vectors, issued back-to-back in the first idle cycle.
      for (int i = 0; i < 10; i++) begin
         push_exp(vecs[i].hi, vecs[i].lo);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
      end

      // Random ops against the reference model.
      for (int i = 0; i < 8; i++) begin
         rop = 4'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
         sbq.push_back(model(rop, ra, rb, m_hi, m_lo));
         run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
      end

      // mthi/mtlo then mfhi/mflo; busy never set.
      seen = 1'b0;
      bus_if.D_md_use = 1'b0; bus_if.E_start = 1'b0;
      @(posedge clk); #1;
      bus_if.E_MDUop = 4'd7; bus_if.E_A = 32'h12345678;
      @(posedge clk); #1;
      seen = seen | bus_if.busy;
      bus_if.E_MDUop = 4'd8; bus_if.E_A = 32'h9ABCDEF0;
      @(posedge clk); #1;
      seen = seen | bus_if.busy;
      bus_if.E_MDUop = 4'd5; bus_if.E_A = 32'd0;
      @(negedge clk);
      chk("mfhi MDUout", bus_if.MDUout, 32'h12345678);
      @(posedge clk); #1;
      bus_if.E_MDUop = 4'd6;
      @(negedge clk);
      chk("mflo MDUout", bus_if.MDUout, 32'h9ABCDEF0);
      bus_if.E_MDUop = 4'd0;
      #1;
      chk("none MDUout", bus_if.MDUout, 32'd0);
      seen = seen | bus_if.busy;
      chk("mt busy_never", 32'(seen), 32'd0);
      m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

      // msub: HI=0, LO=10, then 10 - 2*3.
      mt_pair(32'd0, 32'd10);
`ifdef MDU_MSUB_EN
      push_exp(32'd0, 32'd4);
      run_op(4'd9, 32'd2, 32'd3, "msub_2x3");
      push_exp(32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(4'd9, 32'd1, 32'd5, "msub_wrap");
`else
      bus_if.E_start = 1'b1; bus_if.E_MDUop = 4'd9; bus_if.E_A = 32'd2; bus_if.E_B = 32'd3;
      bus_if.D_md_use = 1'b1;
      #1;
      chk("msub_off stall", 32'(bus_if.stall), 32'd0);
      @(posedge clk); #1;
      bus_if.E_start = 1'b0; bus_if.E_MDUop = 4'd0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen = seen | bus_if.busy;
      end
      chk("msub_off busy", 32'(seen), 32'd0);
      chk("msub_off HI", bus_if.HI, 32'd0);
      chk("msub_off LO", bus_if.LO, 32'd10);
`endif

      // Reset in the middle of a mult: aborts, HI/LO cleared, no later commit.
      mt_pair(32'hA5A5A5A5, 32'h5A5A5A5A);
      bus_if.E_start = 1'b1; bus_if.E_MDUop = 4'd1; bus_if.E_A = 32'd3; bus_if.E_B = 32'd4;
      bus_if.D_md_use = 1'b0;
      @(posedge clk); #1;
      bus_if.E_start = 1'b0; bus_if.E_MDUop = 4'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid busy", 32'(bus_if.busy), 32'd0);
      chk("rst_mid HI", bus_if.HI, 32'd0);
      chk("rst_mid LO", bus_if.LO, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | bus_if.busy;
      end
      chk("rst_mid busy_later", 32'(seen), 32'd0);
      chk("rst_mid HI_later", bus_if.HI, 32'd0);
      chk("rst_mid LO_later", bus_if.LO, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
